pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits.
REQ-002 Parameter CNT_W, default 4: width of the repetition count.
REQ-003 Parameter GAP, default 1: idle cycles inserted between consecutive repetitions; 0 is legal.
REQ-004 Parameter DEF_PAT, default 4'b1010: pattern used when use_def is high.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 start  in  1  request to begin a transmission; sampled only in IDLE.
REQ-008 use_def  in  1  at start, 1 = load DEF_PAT, 0 = load pattern.
REQ-009 pattern  in  PAT_W  user pattern, sent MSB first.
REQ-010 count  in  CNT_W  number of repetitions to send.
REQ-011 abort  in  1  cancels any transmission in progress.
REQ-012 x  out  1  serial output bit, registered.
REQ-013 x_valid  out  1  high on cycles where x carries a pattern bit.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.
REQ-015 done  out  1  one-cycle pulse on normal completion.

Function
REQ-016 FSM states shall be IDLE, SEND, GAP and DONE.
REQ-017 IDLE + start + count!=0 -> SEND; latch the pattern (per use_def) and count into internal registers.
REQ-018 IDLE + start + count==0 -> DONE; no bits are sent.
REQ-019 The first pattern bit (MSB) shall appear on x in the cycle after start is sampled (latency 1).
REQ-020 In SEND, one bit per cycle, MSB to LSB, with x_valid=1 on each.
REQ-021 After the LSB with repetitions remaining: go to GAP if GAP>0, else directly to SEND with the MSB on the next cycle (back-to-back).
REQ-022 GAP shall last exactly GAP cycles with x=0 and x_valid=0, then return to SEND.
REQ-023 After the LSB of the last repetition -> DONE; done=1 for exactly one cycle, then IDLE.
REQ-024 Outside SEND, x=0 and x_valid=0.
REQ-025 start while busy shall be ignored and not queued; pattern, count and use_def changes while busy shall have no effect.
REQ-026 abort shall take priority over all transitions: next state IDLE, x=x_valid=0, no done pulse.
REQ-027 abort and start asserted in the same cycle in IDLE: abort wins and the FSM stays IDLE.
REQ-028 Repetition counter is CNT_W bits and decrements per completed repetition; it shall never wrap.
REQ-029 Bit index counter shall be $clog2(PAT_W) bits wide, or 1 bit when PAT_W=1.
REQ-030 In IDLE, start on the cycle after done shall be accepted, giving a minimum 1-cycle idle between transmissions.

Reset
REQ-031 rst high shall asynchronously force the state to IDLE and x, x_valid, busy, done to 0, and clear all counters and the shift register.
REQ-032 rst asserted mid-transmission shall terminate it without a done pulse; after rst deasserts, the block waits for a new start.

Structure
REQ-033 Shared package pattern_tx_pkg shall hold the state typedef and the default values for PAT_W, CNT_W, GAP and DEF_PAT.
REQ-034 Sub-module pattern_tx_shreg, a loadable PAT_W-bit MSB-first shift register with a reload input, shall be instantiated once; FSM and counters stay in the top.
REQ-035 x, x_valid and done shall come directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-036 use_def=1, count=1, start at cycle 0 -> x=1,0,1,0 with x_valid=1 on cycles 1-4; done=1 on cycle 5; busy=1 on cycles 1-5.
REQ-037 pattern=4'b1101, use_def=0, count=3, GAP=1 -> bits 1101,0,1101,0,1101 over cycles 1-14; done on cycle 15.
REQ-038 GAP=0, count=2, DEF_PAT -> 8 consecutive valid bits 10101010, with no x_valid gap.
REQ-039 count=0 start -> done on cycle 1, x_valid never asserted.
REQ-040 abort on cycle 3 of a count=2 run -> IDLE on cycle 4, no done pulse; a new start on cycle 5 produces a correct full run.
REQ-041 rst pulsed mid-SEND, and start asserted while busy -> all outputs 0 immediately on rst; the busy-time start produces no extra transmission.

Source files
------------

// File: rtl/pattern_tx_pkg.sv
// Shared types and default parameter values for the pattern transmitter.
package pattern_tx_pkg;

    localparam int         PAT_W_DEFAULT   = 4;
    localparam int         CNT_W_DEFAULT   = 4;
    localparam int         GAP_DEFAULT     = 1;
    localparam logic [3:0] DEF_PAT_DEFAULT = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// Control/status bundle between a requester (master) and the pattern transmitter (slave).
interface pattern_tx_if
    import pattern_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             start;
    logic             use_def;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, use_def, pattern, count, abort,
        input  x, x_valid, busy, done
    );

    modport slave (
        input  start, use_def, pattern, count, abort,
        output x, x_valid, busy, done
    );

endinterface

// File: rtl/pattern_tx_shreg.sv
// Rotating MSB-first shift register that keeps a saved copy of the loaded pattern.
// Loads and reloads pre-rotate by one because the MSB is emitted in the same edge.
module pattern_tx_shreg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             reload,
    input  logic [PAT_W-1:0] din,
    output logic             msb,
    output logic             first
);

    logic [PAT_W-1:0] data;
    logic [PAT_W-1:0] saved;

    // Rotate left by one; degenerates to identity when PAT_W is 1.
    function automatic logic [PAT_W-1:0] rotl(input logic [PAT_W-1:0] v);
        return (v << 1) | (v >> (PAT_W - 1));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            saved <= '0;
        end else if (load) begin
            saved <= din;
            data  <= rotl(din);
        end else if (reload) begin
            data <= rotl(saved);
        end else if (shift) begin
            data <= rotl(data);
        end
    end

    assign msb   = data[PAT_W-1];
    assign first = saved[PAT_W-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB first, a given number of
// times, with optional idle gaps between repetitions.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEFAULT,
    parameter int               CNT_W   = CNT_W_DEFAULT,
    parameter int               GAP     = GAP_DEFAULT,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_DEFAULT)
) (
    input logic        clk,
    input logic        rst,
    pattern_tx_if.slave bus
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam bit               BACK2BACK = (GAP == 0);

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap_cnt;
    logic             x_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [PAT_W-1:0] sel_pat;
    logic             at_last;
    logic             more_reps;
    logic             sh_load;
    logic             sh_shift;
    logic             sh_reload;
    logic             sh_msb;
    logic             sh_first;

    // Shift register strobes mirror the FSM transitions below.
    always_comb begin
        sel_pat   = bus.use_def ? DEF_PAT : bus.pattern;
        at_last   = (bit_idx == LAST_IDX);
        more_reps = (reps > CNT_W'(1));
        sh_load   = !bus.abort && (state == S_IDLE) && bus.start && (bus.count != '0);
        sh_shift  = !bus.abort && (state == S_SEND) && !at_last;
        sh_reload = !bus.abort &&
                    (((state == S_SEND) && at_last && more_reps && BACK2BACK) ||
                     ((state == S_GAP) && (gap_cnt == LAST_GAP)));
    end

    pattern_tx_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load   (sh_load),
        .shift  (sh_shift),
        .reload (sh_reload),
        .din    (sel_pat),
        .msb    (sh_msb),
        .first  (sh_first)
    );

    // Outputs default low each cycle; only SEND-bound transitions raise x_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_idx <= '0;
            reps    <= '0;
            gap_cnt <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.abort) begin
                state   <= S_IDLE;
                bit_idx <= '0;
                reps    <= '0;
                gap_cnt <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            busy_q  <= 1'b1;
                            bit_idx <= '0;
                            if (bus.count != '0) begin
                                state   <= S_SEND;
                                reps    <= bus.count;
                                x_q     <= sel_pat[PAT_W-1];
                                valid_q <= 1'b1;
                            end else begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    S_SEND: begin
                        if (!at_last) begin
                            bit_idx <= bit_idx + 1'b1;
                            x_q     <= sh_msb;
                            valid_q <= 1'b1;
                        end else if (more_reps) begin
                            reps    <= reps - 1'b1;
                            bit_idx <= '0;
                            if (BACK2BACK) begin
                                x_q     <= sh_first;
                                valid_q <= 1'b1;
                            end else begin
                                state   <= S_GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            reps   <= '0;
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == LAST_GAP) begin
                            state   <= S_SEND;
                            gap_cnt <= '0;
                            x_q     <= sh_first;
                            valid_q <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.x       = x_q;
    assign bus.x_valid = valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed self-checking bench for pattern_tx: one instance with GAP=1, one with GAP=0.
module tb_pattern_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pattern_tx_if #(.PAT_W(4), .CNT_W(4)) ia ();
    pattern_tx_if #(.PAT_W(4), .CNT_W(4)) ib ();

    pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP(1), .DEF_PAT(4'b1010)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP(0), .DEF_PAT(4'b1010)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] obs_a();
        return {ia.x, ia.x_valid, ia.busy, ia.done};
    endfunction

    function automatic logic [3:0] obs_b();
        return {ib.x, ib.x_valid, ib.busy, ib.done};
    endfunction

    // Expected {x, x_valid, busy, done} per cycle symbol.
    function automatic logic [3:0] code_of(byte c);
        case (c)
            "1":     return 4'b1110;
            "0":     return 4'b0110;
            "g":     return 4'b0010;
            "d":     return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check_output(string tag, logic [3:0] got, logic [3:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic apply_stimulus(bit sel, bit ud, logic [3:0] pat, logic [3:0] cnt);
        if (sel) begin
            ib.use_def = ud;
            ib.pattern = pat;
            ib.count   = cnt;
            ib.start   = 1'b1;
        end else begin
            ia.use_def = ud;
            ia.pattern = pat;
            ia.count   = cnt;
            ia.start   = 1'b1;
        end
    endtask

    // Steps one cycle per symbol; start drops after the first edge. With disturb set,
    // a conflicting start/pattern/count is presented on cycle 3 while the run is busy.
    task automatic run_seq(string tag, string exp, bit sel, bit disturb);
        for (int i = 0; i < exp.len(); i++) begin
            tick();
            if (i == 0) begin
                ia.start = 1'b0;
                ib.start = 1'b0;
            end
            if (disturb && i == 2) begin
                ia.start   = 1'b1;
                ia.use_def = 1'b1;
                ia.pattern = 4'b0000;
                ia.count   = 4'd1;
            end
            if (disturb && i == 3) ia.start = 1'b0;
            check_output($sformatf("%s[%0d]", tag, i + 1), sel ? obs_b() : obs_a(),
                         code_of(exp[i]));
        end
    endtask

    initial begin
        ia.start = 1'b0; ia.use_def = 1'b0; ia.pattern = '0; ia.count = '0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.use_def = 1'b0; ib.pattern = '0; ib.count = '0; ib.abort = 1'b0;

        #2;
        check_output("reset_a", obs_a(), 4'b0000);
        check_output("reset_b", obs_b(), 4'b0000);
        tick();
        rst = 1'b0;

        $display("[TB] default pattern, one repetition");
        apply_stimulus(0, 1, 4'b0000, 4'd1);
        run_seq("def_once", "1010di", 0, 0);

        $display("[TB] user pattern, three repetitions with gap, start right after done");
        apply_stimulus(0, 0, 4'b1101, 4'd3);
        run_seq("gap_rep", "1101g1101g1101di", 0, 1);

        $display("[TB] zero count");
        apply_stimulus(0, 0, 4'b1111, 4'd0);
        run_seq("cnt_zero", "dii", 0, 0);

        $display("[TB] abort mid-run then restart");
        apply_stimulus(0, 1, 4'b0000, 4'd2);
        run_seq("abort_pre", "101", 0, 0);
        ia.abort = 1'b1;
        run_seq("abort_now", "i", 0, 0);
        ia.abort = 1'b0;
        run_seq("abort_idle", "i", 0, 0);
        apply_stimulus(0, 1, 4'b0000, 4'd2);
        run_seq("abort_rerun", "1010g1010di", 0, 0);

        $display("[TB] abort and start together in idle");
        ia.abort = 1'b1;
        apply_stimulus(0, 1, 4'b0000, 4'd1);
        run_seq("abort_start", "ii", 0, 0);
        ia.abort = 1'b0;
        run_seq("abort_start_after", "ii", 0, 0);

        $display("[TB] start while busy, then async reset");
        apply_stimulus(0, 1, 4'b0000, 4'd2);
        run_seq("rst_pre", "10", 0, 0);
        apply_stimulus(0, 0, 4'b0000, 4'd5);
        run_seq("busy_start", "1", 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_async", obs_a(), 4'b0000);
        tick();
        rst = 1'b0;
        run_seq("post_rst", "iiii", 0, 0);

        $display("[TB] back-to-back repetitions with zero gap");
        apply_stimulus(1, 1, 4'b0000, 4'd2);
        run_seq("b2b", "10101010di", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
